vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator, the successor to the fixed 640x480 VGA timing block. Every horizontal and vertical timing interval, the sync polarity and the counter width are parameters. It adds a pixel clock-enable, a display-enable output, line-start and frame-start strobes, and registered outputs. It sits between the pixel clock source and the pixel/colour pipeline, which consumes `de`, `x`, `y` and the strobes.

## Interface
- `H_DISPLAY`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BACK`, 48: horizontal back porch, pixels
- `V_DISPLAY`, 480: active lines per frame
- `V_FRONT`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BACK`, 33: vertical back porch, lines
- `H_POL`, 0: hsync active level (0 = active-low, 1 = active-high)
- `V_POL`, 0: vsync active level
- `CW`, 10: counter/coordinate width
- `pixel_clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `ce`  in  1  pixel enable; counters and outputs advance only when high
- `hs`  out  1  horizontal sync, polarity per `H_POL`
- `vs`  out  1  vertical sync, polarity per `V_POL`
- `de`  out  1  high inside active area
- `x`  out  CW  horizontal count, 0..HT-1
- `y`  out  CW  vertical count, 0..VT-1
- `sol`  out  1  start-of-line strobe
- `sof`  out  1  start-of-frame strobe

## Operation
- Totals: HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK; VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK.
- Elaboration must fail if HT > 2^CW, VT > 2^CW, or any of H_DISPLAY, H_SYNC, V_DISPLAY, V_SYNC is 0. Zero porches are legal.
- Internal counters `hc` and `vc` are CW bits wide.
  - On a cycle with `ce`=1: `hc` wraps HT-1 -> 0, otherwise increments.
  - `vc` changes only when `hc` = HT-1: it wraps VT-1 -> 0, otherwise increments.
  - On a cycle with `ce`=0, both counters hold.
- Output decode of (`hc`, `vc`), registered on a `ce`=1 cycle:
  - `de` <= (hc < H_DISPLAY) & (vc < V_DISPLAY)
  - hsync active when H_DISPLAY+H_FRONT <= hc < H_DISPLAY+H_FRONT+H_SYNC; vsync active when V_DISPLAY+V_FRONT <= vc < V_DISPLAY+V_FRONT+V_SYNC
  - `hs` <= active ? H_POL : !H_POL; `vs` likewise with `V_POL`
  - `x` <= hc; `y` <= vc
  - `sol` <= (hc == 0); `sof` <= (hc == 0) & (vc == 0)
- On a `ce`=0 cycle: `hs`, `vs`, `de`, `x`, `y` hold; `sol` and `sof` are forced to 0. Each strobe is therefore exactly one `pixel_clk` cycle wide.
- `vs` changes only coincident with `x` = 0, i.e. it is aligned to the line start.

## Timing
- Reset takes priority over `ce`. In the cycle after `rst`=1:
  - `hc` = `vc` = 0
  - `hs` = !H_POL, `vs` = !V_POL
  - `de` = 0, `x` = `y` = 0, `sol` = `sof` = 0
- Latency: outputs reflect the counter value of the previous `ce`=1 cycle, so there is one `ce` tick of latency. All outputs change together; there is no skew between `de`, sync and the coordinates.
- First enabled cycle after reset: `sof` = `sol` = 1, `de` = 1, `x` = `y` = 0.
- Line boundary: (x, y) = (HT-1, n) is followed by (0, n+1) with `sol` = 1. Frame boundary: (HT-1, VT-1) is followed by (0, 0) with `sol` = `sof` = 1.
- `ce` gaps mid-line stretch the current pixel with no lost or repeated count. Continuous `ce`=1 gives a frame period of exactly HT*VT clocks.
- Reset asserted mid-frame restarts at (0, 0) on the next enabled cycle, with no partial sync pulse carried over.
- `rst` and `ce` both high in the same cycle: reset applies and the counters do not advance.

## Test plan
- Defaults, `ce`=1: measure the frame.
  - 800 clocks between `sol` pulses; 420000 clocks between `sof` pulses.
  - `de` high 640 clocks per line, for lines 0..479 only.
  - `hs` low for `x` = 656..751; `vs` low for `y` = 490..491.
- Small config (H 8/2/3/1, V 4/1/1/2, H_POL=V_POL=1, CW=4):
  - HT = 14, VT = 8; `hs` high at `x` = 10..12; `vs` high at `y` = 5; `sof` every 112 clocks.
- `ce` toggling 1,0,1,0 (divide-by-2):
  - `x` advances every 2 clocks; `sol` is one clock wide every 1600 clocks.
  - Sync widths double in clocks but stay correct in `ce` ticks.
- Reset at (x, y) = (300, 200):
  - The next cycle shows the reset values.
  - The first `ce` cycle after reset gives `sof` = 1 and `x` = `y` = 0; `vs` is inactive throughout.
- Wrap check at `x` = 799, `y` = 524:
  - Next tick is `x` = 0, `y` = 0 with `sol` = `sof` = 1.
  - `y` never reaches 525; `x` never reaches 800.
- `rst` and `ce` held high together for 5 cycles: outputs stay at reset values and the counters do not advance.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with pixel enable,
// display enable, sync outputs and registered line/frame strobes.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int CW        = 10
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          sol,
  output logic          sof
);

  localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (HT > (1 << CW)) begin : g_bad_ht
    $error("vga_timing_gen: HT does not fit in CW bits");
  end
  if (VT > (1 << CW)) begin : g_bad_vt
    $error("vga_timing_gen: VT does not fit in CW bits");
  end
  if (H_DISPLAY == 0 || H_SYNC == 0 || V_DISPLAY == 0 || V_SYNC == 0) begin : g_bad_zero
    $error("vga_timing_gen: display and sync widths must be non-zero");
  end

  // Bounds are one bit wider than the counters since they may equal 2^CW.
  localparam logic [CW:0] L_HD  = (CW+1)'(H_DISPLAY);
  localparam logic [CW:0] L_HS0 = (CW+1)'(H_DISPLAY + H_FRONT);
  localparam logic [CW:0] L_HS1 = (CW+1)'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CW:0] L_VD  = (CW+1)'(V_DISPLAY);
  localparam logic [CW:0] L_VS0 = (CW+1)'(V_DISPLAY + V_FRONT);
  localparam logic [CW:0] L_VS1 = (CW+1)'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] L_HLAST = CW'(HT - 1);
  localparam logic [CW-1:0] L_VLAST = CW'(VT - 1);

  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;
  logic          r_hs;
  logic          r_vs;
  logic          r_de;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_sol;
  logic          r_sof;

  logic [CW:0] w_hx;
  logic [CW:0] w_vx;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_de;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_h0;
  logic        w_v0;

  assign w_hx     = {1'b0, r_hc};
  assign w_vx     = {1'b0, r_vc};
  assign w_h_last = (r_hc == L_HLAST);
  assign w_v_last = (r_vc == L_VLAST);
  assign w_de     = (w_hx < L_HD) && (w_vx < L_VD);
  assign w_hs_act = (w_hx >= L_HS0) && (w_hx < L_HS1);
  assign w_vs_act = (w_vx >= L_VS0) && (w_vx < L_VS1);
  assign w_h0     = (r_hc == '0);
  assign w_v0     = (r_vc == '0);

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_hc  <= '0;
      r_vc  <= '0;
      r_hs  <= ~H_POL;
      r_vs  <= ~V_POL;
      r_de  <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_sol <= 1'b0;
      r_sof <= 1'b0;
    end else if (ce) begin
      r_hc <= w_h_last ? '0 : r_hc + CW'(1);
      if (w_h_last) begin
        r_vc <= w_v_last ? '0 : r_vc + CW'(1);
      end
      r_hs  <= w_hs_act ? H_POL : ~H_POL;
      r_vs  <= w_vs_act ? V_POL : ~V_POL;
      r_de  <= w_de;
      r_x   <= r_hc;
      r_y   <= r_vc;
      r_sol <= w_h0;
      r_sof <= w_h0 && w_v0;
    end else begin
      // Strobes last exactly one clock even when ce is sparse.
      r_sol <= 1'b0;
      r_sof <= 1'b0;
    end
  end

  assign hs  = r_hs;
  assign vs  = r_vs;
  assign de  = r_de;
  assign x   = r_x;
  assign y   = r_y;
  assign sol = r_sol;
  assign sof = r_sof;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on the small 14x8 raster,
// reference model tracks a linear pixel index within the frame.
module tb_vga_timing_gen;

  localparam int HD = 8, HF = 2, HSW = 3, HB = 1;
  localparam int VD = 4, VF = 1, VSW = 1, VB = 2;
  localparam bit HP = 1'b1, VP = 1'b1;
  localparam int CW = 4;
  localparam int HT = HD + HF + HSW + HB;
  localparam int VT = VD + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce  = 1'b0;
  logic          hs, vs, de, sol, sof;
  logic [CW-1:0] x, y;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .H_POL(HP), .V_POL(VP), .CW(CW)
  ) dut (
    .pixel_clk(clk),
    .rst(rst),
    .ce(ce),
    .hs(hs),
    .vs(vs),
    .de(de),
    .x(x),
    .y(y),
    .sol(sol),
    .sof(sof)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sol;
    logic          sof;
  } out_t;

  out_t q[$];
  out_t last;
  out_t m_exp;
  out_t m_act;
  int   pos = 0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic out_t reset_val();
    out_t r;
    r.hs  = ~HP;
    r.vs  = ~VP;
    r.de  = 1'b0;
    r.x   = '0;
    r.y   = '0;
    r.sol = 1'b0;
    r.sof = 1'b0;
    return r;
  endfunction

  // Output for pixel number p of the frame (row-major scan).
  function automatic out_t decode(input int p);
    out_t r;
    int hc, vc;
    hc = p % HT;
    vc = p / HT;
    r.de  = (hc < HD) && (vc < VD);
    r.hs  = (hc >= HD + HF && hc < HD + HF + HSW) ? HP : ~HP;
    r.vs  = (vc >= VD + VF && vc < VD + VF + VSW) ? VP : ~VP;
    r.x   = CW'(hc);
    r.y   = CW'(vc);
    r.sol = (hc == 0);
    r.sof = (p == 0);
    return r;
  endfunction

  task automatic step(input logic r, input logic c);
    @(negedge clk);
    rst = r;
    ce  = c;
    if (r) begin
      last = reset_val();
      pos  = 0;
    end else if (c) begin
      last = decode(pos);
      pos  = (pos + 1) % FRAME;
    end else begin
      last.sol = 1'b0;
      last.sof = 1'b0;
    end
    q.push_back(last);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      m_exp = q.pop_front();
      m_act = {hs, vs, de, x, y, sol, sof};
      vectors++;
      if (m_act !== m_exp) begin
        miscompares++;
        $display("FAIL vec%0d got hs=%b vs=%b de=%b x=%0d y=%0d sol=%b sof=%b want hs=%b vs=%b de=%b x=%0d y=%0d sol=%b sof=%b",
                 vectors, m_act.hs, m_act.vs, m_act.de, m_act.x, m_act.y,
                 m_act.sol, m_act.sof, m_exp.hs, m_exp.vs, m_exp.de,
                 m_exp.x, m_exp.y, m_exp.sol, m_exp.sof);
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0);
    // Continuous enable across more than two frames and their wraps.
    repeat (2 * FRAME + 20) step(1'b0, 1'b1);
    for (int i = 0; i < 600; i++) step(1'b0, 1'($urandom_range(0, 1)));
    // Divide-by-two enable.
    for (int i = 0; i < 500; i++) step(1'b0, i[0] == 1'b0);
    // Reset while both syncs are active.
    for (int i = 0; i < FRAME && pos != 5 * HT + 11; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b1);
    // Reset and enable together must not advance.
    repeat (5) step(1'b1, 1'b1);
    repeat (FRAME + 5) step(1'b0, 1'b1);
    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0));
    @(negedge clk);
    ce = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
